// File: rtl/inst_mem_pipe_if.sv
// inst_mem_pipe_if: fetch port and program-load port of inst_mem_pipe
//   master : PC/IF stage plus host loader (drives requests, receives responses)
//   slave  : inst_mem_pipe
//   fetch  : fetch_req, pc, fetch_stall -> inst_data, inst_valid, fetch_fault
//   loader : ld_start, ld_base, ld_count, ld_wvalid, ld_wdata -> ld_wready, ld_busy, ld_done
interface inst_mem_pipe_if #(
    parameter int W  = 32,
    parameter int AW = 11
);
    logic         fetch_req;
    logic [W-1:0] pc;
    logic         fetch_stall;
    logic [W-1:0] inst_data;
    logic         inst_valid;
    logic         fetch_fault;
    logic         ld_start;
    logic [W-1:0] ld_base;
    logic [AW:0]  ld_count;
    logic         ld_wvalid;
    logic [W-1:0] ld_wdata;
    logic         ld_wready;
    logic         ld_busy;
    logic         ld_done;
    modport master (
        output fetch_req, pc, fetch_stall, ld_start, ld_base, ld_count, ld_wvalid, ld_wdata,
        input  inst_data, inst_valid, fetch_fault, ld_wready, ld_busy, ld_done
    );
    modport slave (
        input  fetch_req, pc, fetch_stall, ld_start, ld_base, ld_count, ld_wvalid, ld_wdata,
        output inst_data, inst_valid, fetch_fault, ld_wready, ld_busy, ld_done
    );
endinterface

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: instruction memory with registered fetch port and burst loader FSM
//   clk, rst : clock, asynchronous active-high reset
//   bus      : inst_mem_pipe_if.slave (fetch port + program-load port)
//   IMEM_BOUNDS_CHECK_EN : when defined, pc beyond DEPTH words faults; otherwise it wraps
module inst_mem_pipe #(
    parameter int           W         = 32,
    parameter int           DEPTH     = 2048,
    parameter int           AW        = $clog2(DEPTH),
    parameter logic [W-1:0] NOP       = 32'h00000013,
    parameter               INIT_FILE = ""
) (
    input logic            clk,
    input logic            rst,
    inst_mem_pipe_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [W-1:0]  mem [DEPTH];
    logic [1:0]    state;
    logic [AW-1:0] ptr;
    logic [AW:0]   rem;
    logic [AW-1:0] idx;
    logic          bad;
    logic          busy;
    logic          unused_bits;
    assign idx = bus.pc[AW+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
    assign bad         = (|bus.pc[1:0]) || ((bus.pc >> 2) >= W'(DEPTH));
    assign unused_bits = ^{bus.ld_base[W-1:AW+2], bus.ld_base[1:0]};
`else
    assign bad         = |bus.pc[1:0];
    assign unused_bits = ^{bus.ld_base[W-1:AW+2], bus.ld_base[1:0], bus.pc[W-1:AW+2]};
`endif
    assign busy          = state != IDLE;
    assign bus.ld_busy   = busy;
    assign bus.ld_wready = state == LOAD;
    assign bus.ld_done   = state == DONE;
    // Storage is never reset; rst forces IDLE so no write can land while it is held.
    always_ff @(posedge clk)
        if (state == LOAD && bus.ld_wvalid) mem[ptr] <= bus.ld_wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
        end else if (state == IDLE) begin
            if (bus.ld_start) begin
                ptr   <= bus.ld_base[AW+1:2];
                rem   <= bus.ld_count;
                state <= bus.ld_count == '0 ? DONE : LOAD;
            end
        end else if (state == LOAD) begin
            if (bus.ld_wvalid) begin
                ptr <= ptr + AW'(1);
                rem <= rem - (AW+1)'(1);
                if (rem == (AW+1)'(1)) state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    // Stall outranks the loader, so a stalled consumer keeps its instruction through a load.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.inst_data   <= NOP;
            bus.inst_valid  <= 1'b0;
            bus.fetch_fault <= 1'b0;
        end else if (!bus.fetch_stall) begin
            if (busy || !bus.fetch_req) begin
                bus.inst_valid <= 1'b0;
            end else begin
                bus.inst_data   <= bad ? NOP : mem[idx];
                bus.inst_valid  <= 1'b1;
                bus.fetch_fault <= bad;
            end
        end
endmodule

// File: tb/tb_inst_mem_pipe.sv
// tb_inst_mem_pipe: directed self-checking bench for inst_mem_pipe with a word-level model
module tb_inst_mem_pipe;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    inst_mem_pipe_if #(.W(32), .AW(AW)) bus();
    inst_mem_pipe #(.W(32), .DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int busy_cnt = 0;
    int done_cnt = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: memory as an array, loader as "words still owed" plus a done flag.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_data;
    logic        m_valid, m_fault, m_donep;
    int          m_left, m_ptr;
    wire         m_busy = (m_left != 0) || m_donep;
    function automatic logic bad_addr(input logic [31:0] a);
        bad_addr = (a % 4) != 0;
`ifdef IMEM_BOUNDS_CHECK_EN
        if ((a >> 2) >= DEPTH) bad_addr = 1'b1;
`endif
    endfunction
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_data  <= NOP;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
            m_donep <= 1'b0;
            m_left  <= 0;
            m_ptr   <= 0;
        end else begin
            if (!bus.fetch_stall) begin
                if (m_busy || !bus.fetch_req) m_valid <= 1'b0;
                else begin
                    m_valid <= 1'b1;
                    m_fault <= bad_addr(bus.pc);
                    m_data  <= bad_addr(bus.pc) ? NOP : m_mem[(bus.pc >> 2) % DEPTH];
                end
            end
            if (m_donep) m_donep <= 1'b0;
            else if (m_left != 0) begin
                if (bus.ld_wvalid) begin
                    m_mem[m_ptr] <= bus.ld_wdata;
                    m_ptr  <= (m_ptr + 1) % DEPTH;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_donep <= 1'b1;
                end
            end else if (bus.ld_start) begin
                m_ptr <= int'((bus.ld_base >> 2) % DEPTH);
                if (bus.ld_count == 0) m_donep <= 1'b1;
                else m_left <= int'(bus.ld_count);
            end
        end
    always @(negedge clk) begin
        busy_cnt <= busy_cnt + int'(bus.ld_busy);
        done_cnt <= done_cnt + int'(bus.ld_done);
        if (chk_en) begin
            check("m_inst_data", bus.inst_data, m_data);
            check("m_inst_valid", bus.inst_valid, m_valid);
            check("m_fetch_fault", bus.fetch_fault, m_fault);
            check("m_ld_busy", bus.ld_busy, m_busy);
            check("m_ld_wready", bus.ld_wready, m_left != 0);
            check("m_ld_done", bus.ld_done, m_donep);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_load(input logic [31:0] base, input logic [AW:0] n);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        bus.ld_count = n;
        tick();
        bus.ld_start = 1'b0;
    endtask
    task automatic put(input logic [31:0] w);
        bus.ld_wvalid = 1'b1;
        bus.ld_wdata  = w;
        tick();
        bus.ld_wvalid = 1'b0;
    endtask
    task automatic fetch(input logic [31:0] a);
        bus.fetch_req = 1'b1;
        bus.pc        = a;
        tick();
        bus.fetch_req = 1'b0;
    endtask
    int b0, d0;
    initial begin
        bus.fetch_req = 0; bus.pc = 0; bus.fetch_stall = 0;
        bus.ld_start = 0; bus.ld_base = 0; bus.ld_count = 0;
        bus.ld_wvalid = 0; bus.ld_wdata = 0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_inst_data", bus.inst_data, 32'h00000013);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_fetch_fault", bus.fetch_fault, 0);
        check("rst_ld_busy", bus.ld_busy, 0);
        check("rst_ld_wready", bus.ld_wready, 0);
        tick();
        b0 = busy_cnt; d0 = done_cnt;
        start_load(32'h10, 4);
        put(32'h11); put(32'h22); put(32'h33); put(32'h44);
        tick(); tick();
        check("burst4_busy_cycles", busy_cnt - b0, 5);
        check("burst4_done_pulses", done_cnt - d0, 1);
        fetch(32'h18);
        check("fetch18_data", bus.inst_data, 32'h33);
        check("fetch18_valid", bus.inst_valid, 1);
        start_load(32'h24, 2);
        put(32'h55);
        bus.ld_start = 1'b1; bus.ld_base = 32'h0; bus.ld_count = 1;
        tick();
        bus.ld_start = 1'b0;
        tick();
        put(32'h66);
        check("gap_done_after_2nd", bus.ld_done, 1);
        tick();
        check("gap_idle_after_done", bus.ld_busy, 0);
        fetch(32'h24);
        check("gap_word0", bus.inst_data, 32'h55);
        fetch(32'h28);
        check("gap_word1", bus.inst_data, 32'h66);
        fetch(32'h10);
        check("ignored_start_kept_0x10", bus.inst_data, 32'h11);
        start_load((DEPTH - 1) * 4, 2);
        put(32'hE1); put(32'hE2);
        tick();
        fetch(32'h0);
        check("wrap_idx0", bus.inst_data, 32'hE2);
        fetch((DEPTH - 1) * 4);
        check("wrap_idx_last", bus.inst_data, 32'hE1);
        fetch(32'h2);
        check("misalign_data", bus.inst_data, NOP);
        check("misalign_fault", bus.fetch_fault, 1);
        check("misalign_valid", bus.inst_valid, 1);
        fetch(DEPTH * 4);
`ifdef IMEM_BOUNDS_CHECK_EN
        check("oob_data", bus.inst_data, NOP);
        check("oob_fault", bus.fetch_fault, 1);
`else
        check("oob_wrap_data", bus.inst_data, 32'hE2);
        check("oob_wrap_fault", bus.fetch_fault, 0);
`endif
        fetch(32'h18);
        check("prestall_data", bus.inst_data, 32'h33);
        bus.fetch_stall = 1'b1; bus.fetch_req = 1'b1; bus.pc = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", bus.inst_data, 32'h33);
            check("stall_valid", bus.inst_valid, 1);
            check("stall_fault", bus.fetch_fault, 0);
        end
        bus.fetch_stall = 1'b0; bus.fetch_req = 1'b0;
        tick();
        check("unstall_valid", bus.inst_valid, 0);
        check("unstall_hold_data", bus.inst_data, 32'h33);
        start_load(32'h24, 3);
        put(32'hA1);
        bus.ld_wvalid = 1'b1; bus.ld_wdata = 32'hA2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.ld_busy, 0);
        check("midrst_wready", bus.ld_wready, 0);
        tick();
        rst = 1'b0; bus.ld_wvalid = 1'b0;
        tick();
        fetch(32'h24);
        check("midrst_first_word", bus.inst_data, 32'hA1);
        fetch(32'h28);
        check("midrst_second_untouched", bus.inst_data, 32'h66);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
